// File: rtl/md_seq_ctrl_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer:
// funct3 op selects and the 2-bit FSM state encoding.
package md_seq_ctrl_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Datapath for one shift-add multiply or restoring-divide step per clock.
// For divide, acc holds {remainder, dividend/quotient}; for multiply, the product.
module md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplr_q;
    logic [XLEN-1:0]   dvsr_q;

    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_diff;
    logic              rem_ge;
    logic [2*XLEN-1:0] mul_d;
    logic [2*XLEN-1:0] div_d;

    always_comb begin
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        rem_ge   = (rem_sh >= {1'b0, dvsr_q});
        rem_diff = rem_sh - {1'b0, dvsr_q};
        // After a successful subtract the remainder is below the divisor, so XLEN bits suffice.
        div_d = rem_ge ? {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                       : {rem_sh[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0};
        mul_d = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            dvsr_q  <= '0;
        end else if (load) begin
            if (is_div) begin
                acc_q  <= {{XLEN{1'b0}}, a_i};
                dvsr_q <= b_i;
            end else begin
                acc_q   <= '0;
                mcand_q <= {{XLEN{1'b0}}, a_i};
                mplr_q  <= b_i;
            end
        end else if (step) begin
            if (is_div) begin
                acc_q <= div_d;
            end else begin
                acc_q   <= mul_d;
                mcand_q <= {mcand_q[2*XLEN-2:0], 1'b0};
                mplr_q  <= {1'b0, mplr_q[XLEN-1:1]};
            end
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/md_seq_ctrl.sv
// RV32M iterative multiply/divide sequencer: accepts one op, runs 32 steps,
// applies sign fix-up and hands the tagged result back over valid/ready.
module md_seq_ctrl
    import md_seq_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [TAGW-1:0] in_tag,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_tag,
    output logic            busy
);

    md_state_e         state_q;
    logic [5:0]        cnt_q;
    logic [2:0]        f3_q;
    logic [TAGW-1:0]   tag_q;
    logic              sa_q, sb_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   out_result_q;
    logic [TAGW-1:0]   out_tag_q;
    logic              busy_q;

    logic              sgn_a, sgn_b, sa_d, sb_d;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   spec_res_d;
    logic              accept, core_load, core_step, core_is_div;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   fix_res_d;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_ready && in_valid && !flush;

    always_comb begin
        sgn_a = (in_funct3 == F3_MULH) || (in_funct3 == F3_MULHSU) ||
                (in_funct3 == F3_DIV)  || (in_funct3 == F3_REM);
        sgn_b = (in_funct3 == F3_MULH) || (in_funct3 == F3_DIV) || (in_funct3 == F3_REM);
        sa_d  = sgn_a && in_a[XLEN-1];
        sb_d  = sgn_b && in_b[XLEN-1];
        a_mag = sa_d ? (~in_a + 1'b1) : in_a;
        b_mag = sb_d ? (~in_b + 1'b1) : in_b;

        div_zero = in_funct3[2] && (in_b == '0);
        div_ovf  = ((in_funct3 == F3_DIV) || (in_funct3 == F3_REM)) &&
                   (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
        special  = div_zero || div_ovf;
        // Overflow DIV returns the dividend itself (0x80000000); REM gives 0.
        if (div_zero)
            spec_res_d = in_funct3[1] ? in_a : '1;
        else
            spec_res_d = in_funct3[1] ? '0 : in_a;
    end

    assign core_load   = accept;
    assign core_step   = (state_q == ST_CALC) && !flush;
    assign core_is_div = in_ready ? in_funct3[2] : f3_q[2];

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (core_load),
        .step   (core_step),
        .is_div (core_is_div),
        .a_i    (a_mag),
        .b_i    (b_mag),
        .acc_o  (acc)
    );

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? (~acc + 1'b1) : acc;
        quo      = acc[XLEN-1:0];
        rem      = acc[2*XLEN-1:XLEN];
        if (!f3_q[2])
            fix_res_d = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (f3_q[1])
            fix_res_d = sa_q ? (~rem + 1'b1) : rem;
        else
            fix_res_d = (sa_q ^ sb_q) ? (~quo + 1'b1) : quo;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            f3_q         <= '0;
            tag_q        <= '0;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            busy_q       <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        f3_q   <= in_funct3;
                        tag_q  <= in_tag;
                        sa_q   <= sa_d;
                        sb_q   <= sb_d;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (special) begin
                            out_result_q <= spec_res_d;
                            out_tag_q    <= in_tag;
                            out_valid_q  <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(ITERS - 1))
                        state_q <= ST_FIX;
                end
                ST_FIX: begin
                    out_result_q <= fix_res_d;
                    out_tag_q    <= tag_q;
                    out_valid_q  <= 1'b1;
                    state_q      <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Self-checking bench for md_seq_ctrl: directed plan cases plus randomized ops
// checked against an arithmetic reference model.
module tb_md_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        busy;

    int total = 0;
    int bad   = 0;

    md_seq_ctrl #(.XLEN(32), .TAGW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_funct3  (in_funct3),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model straight from the RV32M definitions using 64-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        logic [63:0] p;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 >= 3'd4 && b == 0) return 1'b1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    // Called just after a negedge with the block idle. Returns at the negedge where
    // out_valid is first seen; k is the index of the edge after acceptance (0 = accept edge).
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg, output logic [31:0] res, output logic [4:0] otg,
                         output int k, output int bc);
        in_funct3 = f3; in_a = a; in_b = b; in_tag = tg; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        k = 0; bc = 0;
        @(negedge clk); if (busy) bc++;
        while (!out_valid && k < 100) begin
            @(negedge clk); k++; if (busy) bc++;
        end
        res = out_result; otg = out_tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_funct3 = '0; in_a = '0; in_b = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %0b want 0", out_valid); end
        total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset out_result: got %h want 0", out_result); end
        total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL reset out_tag: got %h want 0", out_tag); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %0b want 0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %0b want 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mul_timing();
        logic [31:0] r; logic [4:0] t; int k, bc;
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd21, r, t, k, bc);
        total++; if (r !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_result: got %h want ffffffeb", r); end
        total++; if (t !== 5'd21) begin bad++; $display("FAIL mul_tag: got %0d want 21", t); end
        total++; if (k != 33) begin bad++; $display("FAIL mul_latency: got %0d want 33", k); end
        @(negedge clk);
        total++; if (bc != 34 || busy !== 1'b0) begin bad++; $display("FAIL mul_busy_len: got %0d busy_after=%0b want 34/0", bc, busy); end
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL mul_dequeue: in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [11] = '{3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                  32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7,
                                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exs [11] = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                  32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        int          lats[11] = '{33, 33, 33, 33, 33, 33, 33, 0, 0, 0, 0};
        logic [31:0] r; logic [4:0] t; int k, bc;
        for (int i = 0; i < 11; i++) begin
            do_op(f3s[i], as[i], bs[i], 5'(i + 3), r, t, k, bc);
            total++; if (r !== exs[i]) begin bad++; $display("FAIL directed_result[%0d]: got %h want %h", i, r, exs[i]); end
            total++; if (t !== 5'(i + 3)) begin bad++; $display("FAIL directed_tag[%0d]: got %0d want %0d", i, t, i + 3); end
            total++; if (k != lats[i]) begin bad++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, k, lats[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, a, b, e; logic [4:0] t, tg; logic [2:0] f3; int k, bc, el;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 6))
                0: a = 32'h0; 1: a = 32'h1; 2: a = 32'hFFFF_FFFF; 3: a = 32'h8000_0000; default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'h0; 1: b = 32'h1; 2: b = 32'hFFFF_FFFF; 3: b = 32'h8000_0000; default: b = $urandom;
            endcase
            tg = 5'($urandom_range(0, 31));
            e  = ref_res(f3, a, b);
            el = is_special(f3, a, b) ? 0 : 33;
            do_op(f3, a, b, tg, r, t, k, bc);
            total++; if (r !== e || t !== tg || k != el) begin
                bad++;
                $display("FAIL random[%0d] f3=%0d a=%h b=%h: got res=%h tag=%0d lat=%0d want res=%h tag=%0d lat=%0d",
                         i, f3, a, b, r, t, k, e, tg, el);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush_beats_valid();
        in_funct3 = 3'd0; in_a = 32'd3; in_b = 32'd4; in_tag = 5'd1;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_vs_valid: busy=%0b in_ready=%0b want 0/1", busy, in_ready); end
    endtask

    // Kill an op in its 10th CALC cycle, either with flush or with reset.
    task automatic test_kill(input bit use_rst);
        logic [31:0] r; logic [4:0] t; int k, bc; bit seen;
        do_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd17, r, t, k, bc);
        @(negedge clk);
        in_funct3 = 3'd1; in_a = 32'h1357_9BDF; in_b = 32'h2468_ACE0; in_tag = 5'd9; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        if (use_rst) rst_n = 1'b0; else flush = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1; flush = 1'b0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL kill_state(rst=%0b): in_ready=%0b busy=%0b out_valid=%0b want 1/0/0", use_rst, in_ready, busy, out_valid);
        end
        if (use_rst) begin
            total++; if (out_result !== 32'h0 || out_tag !== 5'h0) begin
                bad++; $display("FAIL kill_rst_outputs: result=%h tag=%0d want 0/0", out_result, out_tag);
            end
        end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        total++; if (seen) begin bad++; $display("FAIL kill_no_result(rst=%0b): out_valid rose after kill", use_rst); end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic [4:0] t; int k, bc;
        out_ready = 1'b0;
        do_op(3'd5, 32'd100, 32'd7, 5'd9, r, t, k, bc);
        total++; if (r !== 32'd14 || t !== 5'd9) begin bad++; $display("FAIL bp_result: got %h/%0d want 0000000e/9", r, t); end
        // Offer the next op while DONE is stalled; it must wait for IDLE.
        in_funct3 = 3'd7; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd3; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || out_result !== 32'd14 || out_tag !== 5'd9 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d]: valid=%0b result=%h tag=%0d in_ready=%0b want 1/0000000e/9/0",
                                i, out_valid, out_result, out_tag, in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_dequeue: valid=%0b busy=%0b in_ready=%0b want 0/0/1", out_valid, busy, in_ready);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        k = 0;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_next_accept: busy=%0b want 1", busy); end
        while (!out_valid && k < 100) begin @(negedge clk); k++; end
        total++; if (out_result !== 32'd2 || out_tag !== 5'd3 || k != 33) begin
            bad++; $display("FAIL bp_next_result: got %h/%0d lat=%0d want 00000002/3 lat=33", out_result, out_tag, k);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_directed();
        test_random();
        test_flush_beats_valid();
        test_kill(1'b0);
        test_kill(1'b1);
        test_backpressure();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
